// File: rtl/wb_serial_loader.sv
// Pipelined Wishbone master that drains bytes from a serial port slave and packs
// them little-endian into 32-bit words written to memory, one access at a time.
module wb_serial_loader #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_bus,
  input  logic        rst_bus,
  input  logic        start,
  input  logic [31:0] serial_base,
  input  logic [31:0] mem_base,
  input  logic [15:0] len_words,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i,
  input  logic        stall_i,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, POLL, RDBYTE, WRITE, DONE, ERR} state_e;

  state_e        state_q;
  logic [31:0]   serialBase_q;
  logic [31:0]   memBase_q;
  logic [15:0]   lenWords_q;
  logic [15:0]   wordIdx_q;
  logic [1:0]    byteCnt_q;
  logic [3:0]    burst_q;
  logic [31:0]   word_q;
  logic [TW-1:0] tmr_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic          we_q;
  logic          cyc_q;
  logic          stb_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;

  logic [31:0]   rxWord;
  logic [31:0]   writeAdr;
  logic          timedOut;
  logic          unusedDatHi;

  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign we_o  = we_q;
  assign cyc_o = cyc_q;
  assign stb_o = stb_q;
  assign sel_o = 4'hF;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

  // Only the low byte of a serial read carries data; the rest of the bus is ignored.
  assign unusedDatHi = ^dat_i[31:8];

  always_comb begin
    rxWord = word_q;
    case (byteCnt_q)
      2'd0:    rxWord[7:0]   = dat_i[7:0];
      2'd1:    rxWord[15:8]  = dat_i[7:0];
      2'd2:    rxWord[23:16] = dat_i[7:0];
      default: rxWord[31:24] = dat_i[7:0];
    endcase
    writeAdr = memBase_q + {14'd0, wordIdx_q, 2'b00};
    timedOut = !stb_q && (tmr_q == TW'(TIMEOUT - 1));
  end

  // Each bus state keeps cyc_o high until a response; the follow-up access is
  // launched at the response edge so the next request appears the very next cycle.
  always_ff @(posedge clk_bus) begin
    if (rst_bus) begin
      state_q      <= IDLE;
      serialBase_q <= '0;
      memBase_q    <= '0;
      lenWords_q   <= '0;
      wordIdx_q    <= '0;
      byteCnt_q    <= '0;
      burst_q      <= '0;
      word_q       <= '0;
      tmr_q        <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            serialBase_q <= serial_base;
            memBase_q    <= mem_base;
            lenWords_q   <= len_words;
            wordIdx_q    <= '0;
            byteCnt_q    <= '0;
            burst_q      <= '0;
            word_q       <= '0;
            tmr_q        <= '0;
            error_q      <= 1'b0;
            if (len_words == 16'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= POLL;
              busy_q  <= 1'b1;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b0;
              adr_q   <= serial_base | 32'd1;
            end
          end
        end

        POLL, RDBYTE, WRITE: begin
          if (stb_q && !stall_i) begin
            stb_q <= 1'b0;
            tmr_q <= '0;
          end else if (!stb_q) begin
            tmr_q <= tmr_q + TW'(1);
          end

          if (err_i || (timedOut && !ack_i && !rty_i)) begin
            state_q <= ERR;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else if (rty_i) begin
            stb_q <= 1'b1;
          end else if (ack_i) begin
            if (state_q == POLL) begin
              stb_q <= 1'b1;
              if (dat_i[7:4] != 4'd0) begin
                burst_q <= dat_i[7:4];
                state_q <= RDBYTE;
                adr_q   <= serialBase_q;
              end
            end else if (state_q == RDBYTE) begin
              word_q    <= rxWord;
              byteCnt_q <= byteCnt_q + 2'd1;
              burst_q   <= burst_q - 4'd1;
              stb_q     <= 1'b1;
              if (byteCnt_q == 2'd3) begin
                state_q <= WRITE;
                adr_q   <= writeAdr;
                dat_q   <= rxWord;
                we_q    <= 1'b1;
              end else if (burst_q <= 4'd1) begin
                state_q <= POLL;
                adr_q   <= serialBase_q | 32'd1;
              end
            end else begin
              wordIdx_q <= wordIdx_q + 16'd1;
              we_q      <= 1'b0;
              if ((wordIdx_q + 16'd1) == lenWords_q) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
              end else if (burst_q != 4'd0) begin
                state_q <= RDBYTE;
                stb_q   <= 1'b1;
                adr_q   <= serialBase_q;
              end else begin
                state_q <= POLL;
                stb_q   <= 1'b1;
                adr_q   <= serialBase_q | 32'd1;
              end
            end
          end
        end

        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_serial_loader.sv
// Directed bench for wb_serial_loader: a scripted Wishbone slave answers each
// accepted access in order and logs it for the per-scenario checks.
module tb_wb_serial_loader;

  localparam int TO     = 16;
  localparam int K_ACK  = 0;
  localparam int K_RTY  = 1;
  localparam int K_ERR  = 2;
  localparam int K_NONE = 3;

  logic        clk_bus = 1'b0;
  logic        rst_bus;
  logic        start;
  logic [31:0] serial_base;
  logic [31:0] mem_base;
  logic [15:0] len_words;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel_o;
  logic        we_o, cyc_o, stb_o;
  logic        ack_i, err_i, rty_i, stall_i;
  logic        busy, done, error;

  typedef struct { int kind; logic [31:0] rdata; int stall; } resp_t;
  typedef struct { logic [31:0] adr; logic [31:0] dat; logic we; int stbCycles; } acc_t;

  resp_t script[$];
  acc_t  accLog[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    forceAck = 1'b0;

  wb_serial_loader #(.TIMEOUT(TO)) dut (
    .clk_bus(clk_bus), .rst_bus(rst_bus), .start(start),
    .serial_base(serial_base), .mem_base(mem_base), .len_words(len_words),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o),
    .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i), .stall_i(stall_i),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk_bus = ~clk_bus;

  // Slave: pops one script entry per access, stalls as told, answers the cycle after acceptance.
  initial begin : slave
    resp_t cur;
    bit    pend;
    int    stallLeft;
    int    stbCnt;
    pend = 1'b0; stallLeft = -1; stbCnt = 0;
    cur = '{K_ACK, 32'h0, 0};
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; stall_i = 1'b0; dat_i = '0;
    forever begin
      @(negedge clk_bus);
      ack_i = forceAck; err_i = 1'b0; rty_i = 1'b0; stall_i = 1'b0;
      if (rst_bus) begin
        pend = 1'b0; stallLeft = -1; stbCnt = 0;
      end else begin
        if (pend) begin
          pend = 1'b0;
          case (cur.kind)
            K_ACK: begin ack_i = 1'b1; dat_i = cur.rdata; end
            K_RTY: rty_i = 1'b1;
            K_ERR: err_i = 1'b1;
            default: ;
          endcase
        end
        if (cyc_o && stb_o) begin
          if (stallLeft < 0) begin
            if (script.size() > 0) cur = script.pop_front();
            else cur = '{K_ACK, 32'h0, 0};
            stallLeft = cur.stall;
          end
          stbCnt++;
          if (stallLeft > 0) begin
            stall_i = 1'b1;
            stallLeft--;
          end else begin
            accLog.push_back('{adr_o, dat_o, we_o, stbCnt});
            stbCnt = 0;
            stallLeft = -1;
            pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic doStart(input logic [31:0] sb, input logic [31:0] mb, input logic [15:0] n);
    @(negedge clk_bus);
    serial_base = sb; mem_base = mb; len_words = n; start = 1'b1;
    @(negedge clk_bus);
    start = 1'b0;
  endtask

  task automatic waitEnd(input int budget, output bit sawDone, output bit sawErr, output int waitCycles);
    sawDone = 1'b0; sawErr = 1'b0; waitCycles = 0;
    for (int i = 0; i < budget && !sawDone && !sawErr; i++) begin
      @(negedge clk_bus);
      if (cyc_o && !stb_o) waitCycles++;
      if (done) sawDone = 1'b1;
      if (error) sawErr = 1'b1;
    end
  endtask

  task automatic pushWord(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    script.push_back('{K_ACK, {24'h0, b0}, 0});
    script.push_back('{K_ACK, {24'h0, b1}, 0});
    script.push_back('{K_ACK, {24'h0, b2}, 0});
    script.push_back('{K_ACK, {24'h0, b3}, 0});
  endtask

  task automatic test_reset();
    rst_bus = 1'b1; start = 1'b0; serial_base = '0; mem_base = '0; len_words = '0;
    repeat (3) @(negedge clk_bus);
    vectors++;
    if ({cyc_o, stb_o, we_o, busy, done, error} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 000000", {cyc_o, stb_o, we_o, busy, done, error});
    end
    vectors++;
    if ({adr_o, dat_o} !== 64'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_adr_dat: got %h, expected 0", {adr_o, dat_o});
    end
    vectors++;
    if (sel_o !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL reset_sel: got %h, expected f", sel_o);
    end
    rst_bus = 1'b0;
  endtask

  task automatic test_zero_len();
    accLog.delete(); script.delete();
    doStart(32'h2000, 32'h1000, 16'd0);
    vectors++;
    if ({done, cyc_o, busy} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL zero_len_done: got done/cyc/busy %b, expected 100", {done, cyc_o, busy});
    end
    @(negedge clk_bus);
    vectors++;
    if (done !== 1'b0 || accLog.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL zero_len_after: got done %b accesses %0d, expected 0 0", done, accLog.size());
    end
  endtask

  task automatic test_single_word();
    bit d, e; int w;
    accLog.delete(); script.delete();
    script.push_back('{K_ACK, 32'h00, 0});
    script.push_back('{K_ACK, 32'h00, 0});
    script.push_back('{K_ACK, 32'h40, 0});
    pushWord(8'h11, 8'h22, 8'h33, 8'h44);
    script.push_back('{K_ACK, 32'h0, 0});
    doStart(32'h2000, 32'h1000, 16'd1);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_busy: got %b, expected 1", busy);
    end
    waitEnd(200, d, e, w);
    vectors++;
    if (d !== 1'b1 || accLog.size() != 8) begin
      miscompares++;
      $display("[TB] FAIL single_done: got done %b accesses %0d, expected 1 8", d, accLog.size());
    end
    if (accLog.size() == 8) begin
      vectors++;
      if (accLog[0].adr !== 32'h2001 || accLog[2].adr !== 32'h2001 || accLog[3].adr !== 32'h2000) begin
        miscompares++;
        $display("[TB] FAIL single_read_adr: got %h %h %h, expected 2001 2001 2000", accLog[0].adr, accLog[2].adr, accLog[3].adr);
      end
      vectors++;
      if ({accLog[7].we, accLog[7].adr, accLog[7].dat} !== {1'b1, 32'h1000, 32'h44332211}) begin
        miscompares++;
        $display("[TB] FAIL single_write: got we %b adr %h dat %h, expected 1 1000 44332211", accLog[7].we, accLog[7].adr, accLog[7].dat);
      end
    end
    @(negedge clk_bus);
    vectors++;
    if ({done, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL single_done_pulse: got done/busy %b, expected 00", {done, busy});
    end
  endtask

  task automatic test_two_words();
    bit d, e; int w; int reads; int writes;
    logic [31:0] wrAdr[2];
    logic [31:0] wrDat[2];
    accLog.delete(); script.delete();
    script.push_back('{K_ACK, 32'h30, 0});
    script.push_back('{K_ACK, 32'h01, 0});
    script.push_back('{K_ACK, 32'h02, 0});
    script.push_back('{K_ACK, 32'h03, 0});
    script.push_back('{K_ACK, 32'h50, 0});
    script.push_back('{K_ACK, 32'h04, 0});
    script.push_back('{K_ACK, 32'h00, 0});
    pushWord(8'h05, 8'h06, 8'h07, 8'h08);
    script.push_back('{K_ACK, 32'h00, 0});
    doStart(32'h2000, 32'h1000, 16'd2);
    waitEnd(300, d, e, w);
    repeat (3) @(negedge clk_bus);
    reads = 0; writes = 0;
    wrAdr[0] = '0; wrAdr[1] = '0; wrDat[0] = '0; wrDat[1] = '0;
    foreach (accLog[i]) begin
      if (!accLog[i].we && accLog[i].adr == 32'h2000) reads++;
      if (accLog[i].we) begin
        if (writes < 2) begin
          wrAdr[writes] = accLog[i].adr;
          wrDat[writes] = accLog[i].dat;
        end
        writes++;
      end
    end
    vectors++;
    if (d !== 1'b1 || reads != 8 || writes != 2) begin
      miscompares++;
      $display("[TB] FAIL two_counts: got done %b reads %0d writes %0d, expected 1 8 2", d, reads, writes);
    end
    vectors++;
    if ({wrAdr[0], wrAdr[1]} !== {32'h1000, 32'h1004}) begin
      miscompares++;
      $display("[TB] FAIL two_write_adr: got %h %h, expected 1000 1004", wrAdr[0], wrAdr[1]);
    end
    vectors++;
    if ({wrDat[0], wrDat[1]} !== {32'h04030201, 32'h08070605}) begin
      miscompares++;
      $display("[TB] FAIL two_write_dat: got %h %h, expected 04030201 08070605", wrDat[0], wrDat[1]);
    end
  endtask

  task automatic test_truncate();
    bit d, e; int w;
    accLog.delete(); script.delete();
    script.push_back('{K_ACK, 32'hF0, 0});
    pushWord(8'h9A, 8'hBC, 8'hDE, 8'hF0);
    script.push_back('{K_ACK, 32'h0, 0});
    doStart(32'h4000, 32'hFFFF_FFFC, 16'd1);
    waitEnd(200, d, e, w);
    repeat (4) @(negedge clk_bus);
    vectors++;
    if (d !== 1'b1 || accLog.size() != 6 || cyc_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL truncate_count: got done %b accesses %0d cyc %b, expected 1 6 0", d, accLog.size(), cyc_o);
    end
    if (accLog.size() == 6) begin
      vectors++;
      if ({accLog[5].adr, accLog[5].dat} !== {32'hFFFF_FFFC, 32'hF0DEBC9A}) begin
        miscompares++;
        $display("[TB] FAIL truncate_write: got %h %h, expected fffffffc f0debc9a", accLog[5].adr, accLog[5].dat);
      end
    end
  endtask

  task automatic test_stall_write();
    bit d, e; int w;
    accLog.delete(); script.delete();
    script.push_back('{K_ACK, 32'h40, 0});
    pushWord(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    script.push_back('{K_ACK, 32'h0, 3});
    doStart(32'h2000, 32'h1000, 16'd1);
    waitEnd(200, d, e, w);
    vectors++;
    if (d !== 1'b1 || accLog.size() != 6) begin
      miscompares++;
      $display("[TB] FAIL stall_done: got done %b accesses %0d, expected 1 6", d, accLog.size());
    end
    if (accLog.size() == 6) begin
      vectors++;
      if (accLog[5].stbCycles != 4 || accLog[5].dat !== 32'hD4C3B2A1 || accLog[5].we !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stall_write: got stb cycles %0d dat %h we %b, expected 4 d4c3b2a1 1", accLog[5].stbCycles, accLog[5].dat, accLog[5].we);
      end
    end
  endtask

  task automatic test_retry_read();
    bit d, e; int w;
    accLog.delete(); script.delete();
    script.push_back('{K_ACK, 32'h40, 0});
    script.push_back('{K_RTY, 32'h0, 0});
    pushWord(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    script.push_back('{K_ACK, 32'h0, 0});
    doStart(32'h2000, 32'h1000, 16'd1);
    waitEnd(200, d, e, w);
    vectors++;
    if (d !== 1'b1 || accLog.size() != 7) begin
      miscompares++;
      $display("[TB] FAIL retry_done: got done %b accesses %0d, expected 1 7", d, accLog.size());
    end
    if (accLog.size() == 7) begin
      vectors++;
      if ({accLog[1].adr, accLog[1].we, accLog[2].adr, accLog[2].we} !== {32'h2000, 1'b0, 32'h2000, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL retry_reissue: got %h/%b %h/%b, expected 2000/0 2000/0", accLog[1].adr, accLog[1].we, accLog[2].adr, accLog[2].we);
      end
      vectors++;
      if (accLog[6].dat !== 32'hDDCCBBAA) begin
        miscompares++;
        $display("[TB] FAIL retry_data: got %h, expected ddccbbaa", accLog[6].dat);
      end
    end
  endtask

  task automatic test_err_write();
    bit d, e; int w;
    accLog.delete(); script.delete();
    script.push_back('{K_ACK, 32'h40, 0});
    pushWord(8'h01, 8'h02, 8'h03, 8'h04);
    script.push_back('{K_ERR, 32'h0, 0});
    doStart(32'h2000, 32'h1000, 16'd1);
    waitEnd(200, d, e, w);
    vectors++;
    if ({e, d, error, busy, cyc_o, stb_o} !== 6'b101000) begin
      miscompares++;
      $display("[TB] FAIL err_enter: got err/done/error/busy/cyc/stb %b, expected 101000", {e, d, error, busy, cyc_o, stb_o});
    end
    @(negedge clk_bus);
    vectors++;
    if ({error, busy, done} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL err_sticky: got error/busy/done %b, expected 100", {error, busy, done});
    end
  endtask

  task automatic test_timeout();
    bit d, e; int w;
    accLog.delete(); script.delete();
    script.push_back('{K_NONE, 32'h0, 0});
    doStart(32'h2000, 32'h1000, 16'd1);
    vectors++;
    if ({error, busy} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL timeout_start_clears: got error/busy %b, expected 01", {error, busy});
    end
    waitEnd(100, d, e, w);
    vectors++;
    if (e !== 1'b1 || w != TO) begin
      miscompares++;
      $display("[TB] FAIL timeout_wait: got err %b wait cycles %0d, expected 1 %0d", e, w, TO);
    end
    vectors++;
    if ({cyc_o, stb_o, busy, error} !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL timeout_outputs: got cyc/stb/busy/error %b, expected 0001", {cyc_o, stb_o, busy, error});
    end
    @(negedge clk_bus);
    doStart(32'h2000, 32'h1000, 16'd0);
    vectors++;
    if ({error, done} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL restart_clears_error: got error/done %b, expected 01", {error, done});
    end
  endtask

  task automatic test_back_to_back();
    bit d, e; int w; int writes;
    accLog.delete(); script.delete();
    script.push_back('{K_ACK, 32'h40, 0});
    pushWord(8'h55, 8'h66, 8'h77, 8'h88);
    script.push_back('{K_ACK, 32'h0, 0});
    doStart(32'h2000, 32'h1000, 16'd1);
    doStart(32'h3000, 32'h5000, 16'd0);
    vectors++;
    if ({done, busy} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL b2b_ignored: got done/busy %b, expected 01", {done, busy});
    end
    waitEnd(200, d, e, w);
    writes = 0;
    foreach (accLog[i]) if (accLog[i].we) writes++;
    vectors++;
    if (d !== 1'b1 || writes != 1 || accLog.size() != 6) begin
      miscompares++;
      $display("[TB] FAIL b2b_done: got done %b writes %0d accesses %0d, expected 1 1 6", d, writes, accLog.size());
    end
    if (accLog.size() == 6) begin
      vectors++;
      if ({accLog[0].adr, accLog[5].adr, accLog[5].dat} !== {32'h2001, 32'h1000, 32'h88776655}) begin
        miscompares++;
        $display("[TB] FAIL b2b_latched: got %h %h %h, expected 2001 1000 88776655", accLog[0].adr, accLog[5].adr, accLog[5].dat);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    accLog.delete(); script.delete();
    script.push_back('{K_NONE, 32'h0, 0});
    doStart(32'h2000, 32'h1000, 16'd1);
    @(negedge clk_bus);
    vectors++;
    if ({cyc_o, stb_o} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL mid_pending: got cyc/stb %b, expected 10", {cyc_o, stb_o});
    end
    rst_bus = 1'b1;
    @(negedge clk_bus);
    rst_bus = 1'b0;
    vectors++;
    if ({cyc_o, stb_o, busy} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_drop: got cyc/stb/busy %b, expected 000", {cyc_o, stb_o, busy});
    end
    forceAck = 1'b1;
    repeat (2) @(negedge clk_bus);
    forceAck = 1'b0;
    repeat (2) @(negedge clk_bus);
    vectors++;
    if ({cyc_o, stb_o, busy, done, error} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL mid_late_ack: got cyc/stb/busy/done/error %b, expected 00000", {cyc_o, stb_o, busy, done, error});
    end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_single_word();
    test_two_words();
    test_truncate();
    test_stall_write();
    test_retry_read();
    test_err_write();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
